serial_adder_ctrl: RTL

- Bit-serial adder controller: accepts a pair of WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Sequences a single instance of the team's 1-bit fulladder cell, one bit per clock, LSB first. A carry flip-flop links the bits.
- Presents the WIDTH-bit sum and carry-out on an output valid/ready handshake.
- Used where area matters more than throughput; it is the scheduler that time-shares one fulladder across all bit positions.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_ctrl_if.sv | 24 ++
 rtl/serial_adder_ctrl_fulladder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand-in / result-out handshake bundle for serial_adder_ctrl.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/serial_adder_ctrl_fulladder.sv
// The shared 1-bit full adder cell that the controller time-shares.
module fulladder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder scheduler: one fulladder, one bit per clock, LSB first.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | shifting one bit through the fulladder per clock
// DONE  | result held on sum/cout until out_ready
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_ctrl_if.slave   io,
    output logic                 busy
);
    import serial_adder_pkg::*;

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic             fa_sum;
    logic             fa_cout;

    fulladder u_fa (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_sh_d     = io.a;
                    b_sh_d     = io.b;
                    carry_d    = io.cin;
                    cnt_d      = '0;
                    sum_d      = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                carry_d = fa_cout;
                // Counter parks at the last bit so it never wraps.
                if (cnt_q == CNT_LAST) begin
                    cout_d      = fa_cout;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.sum       = sum_q;
    assign io.cout      = cout_q;
    assign busy         = busy_q;

endmodule
